// File: rtl/lgn_frame_streamer_if.sv
// Host/core side signal bundle of the LGN frame streamer: pattern RAM write
// port, run controls, the byte link to the core and the captured results.
interface lgn_frame_streamer_if #(
    parameter int ADDR_W  = 7,
    parameter int PAT_W   = 2,
    parameter int INDEX_W = 4
);
    logic [1:0]         mode;
    logic               start;
    logic               next_pat;
    logic               pat_we;
    logic [ADDR_W-1:0]  pat_addr;
    logic [7:0]         pat_wdata;
    logic [7:0]         core_ui_in;
    logic [INDEX_W-1:0] core_index;
    logic [7:0]         core_value;
    logic               frame_start;
    logic [PAT_W-1:0]   pat_sel;
    logic [INDEX_W-1:0] res_index;
    logic [7:0]         res_value;
    logic               res_valid;
    logic               res_stable;
    logic               busy;

    modport master (
        input  mode, start, next_pat, pat_we, pat_addr, pat_wdata,
        input  core_index, core_value,
        output core_ui_in, frame_start, pat_sel,
        output res_index, res_value, res_valid, res_stable, busy
    );

    modport slave (
        output mode, start, next_pat, pat_we, pat_addr, pat_wdata,
        output core_index, core_value,
        input  core_ui_in, frame_start, pat_sel,
        input  res_index, res_value, res_valid, res_stable, busy
    );
endinterface

// File: rtl/lgn_frame_streamer.sv
// Frame RAM feeder for the LGN MNIST core: streams one stored bitmap byte per
// clock and samples the core's classification once per complete frame.
module lgn_frame_streamer #(
    parameter int BYTES_PER_FRAME = 32,
    parameter int NUM_PATTERNS    = 4,
    parameter int CAPTURE_OFFSET  = 1,
    parameter int AUTO_PERIOD     = 6000000,
    parameter int STABLE_COUNT    = 3,
    parameter int INDEX_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lgn_frame_streamer_if.master bus
);
    localparam int CNT_W  = $clog2(BYTES_PER_FRAME);
    localparam int PAT_W  = $clog2(NUM_PATTERNS);
    localparam int ADDR_W = CNT_W + PAT_W;
    localparam int DEPTH  = NUM_PATTERNS * BYTES_PER_FRAME;
    localparam int TMR_W  = $clog2(AUTO_PERIOD);
    localparam int STB_W  = $clog2(STABLE_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPTURE_OFFSET);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_COUNT);

    localparam logic [1:0] MODE_STOP   = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_AUTO   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_DRAIN  = 2'b10
    } state_t;

    logic [7:0]         mem_r [DEPTH];
    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [TMR_W-1:0]   tmr_r;
    logic [STB_W-1:0]   stb_r;
    logic [STB_W-1:0]   stb_nxt_s;
    logic [PAT_W-1:0]   pat_sel_r;
    logic               primed_r;
    logic               pend_r;
    logic               next_pat_d_r;
    logic [7:0]         core_ui_in_r;
    logic               frame_start_r;
    logic [INDEX_W-1:0] res_index_r;
    logic [7:0]         res_value_r;
    logic               res_valid_r;
    logic               res_stable_r;
    logic               busy_r;

    logic               rise_s;
    logic               stream_s;
    logic               expire_s;
    logic               wrap_s;
    logic               capture_s;
    logic               adv_s;
    logic [ADDR_W-1:0]  rd_addr_s;

    // Frame events, advance requests, stability update and next state
    always_comb begin
        rise_s    = bus.next_pat & ~next_pat_d_r;
        stream_s  = (state_r == ST_STREAM);
        expire_s  = stream_s && (bus.mode == MODE_AUTO) && (tmr_r == TMR_LAST);
        wrap_s    = (state_r != ST_IDLE) && (cnt_r == CNT_LAST);
        capture_s = (state_r != ST_IDLE) && primed_r && (cnt_r == CNT_CAP);
        rd_addr_s = {pat_sel_r, cnt_r};

        // Outside IDLE an advance waits for the frame boundary so frames are never split.
        if (state_r == ST_IDLE) begin
            adv_s = pend_r | rise_s;
        end else begin
            adv_s = wrap_s & (pend_r | rise_s | expire_s);
        end

        stb_nxt_s = stb_r;
        if (adv_s) begin
            stb_nxt_s = {STB_W{1'b0}};
        end else if (capture_s) begin
            if (bus.core_index != res_index_r) begin
                stb_nxt_s = STB_W'(1);
            end else if (stb_r != STB_MAX) begin
                stb_nxt_s = stb_r + STB_W'(1);
            end else begin
                stb_nxt_s = stb_r;
            end
        end else begin
            stb_nxt_s = stb_r;
        end

        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((bus.mode == MODE_CONT) || (bus.mode == MODE_AUTO) ||
                    ((bus.mode == MODE_SINGLE) && bus.start)) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (wrap_s) begin
                    case (bus.mode)
                        MODE_STOP:   state_nxt_s = ST_IDLE;
                        MODE_SINGLE: state_nxt_s = ST_DRAIN;
                        default:     state_nxt_s = ST_STREAM;
                    endcase
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                // A drain that lost its primed flag to an advance gives up at the wrap.
                if (capture_s || wrap_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control FSM, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            tmr_r         <= {TMR_W{1'b0}};
            stb_r         <= {STB_W{1'b0}};
            pat_sel_r     <= {PAT_W{1'b0}};
            primed_r      <= 1'b0;
            pend_r        <= 1'b0;
            next_pat_d_r  <= 1'b0;
            core_ui_in_r  <= 8'h00;
            frame_start_r <= 1'b0;
            res_index_r   <= {INDEX_W{1'b0}};
            res_value_r   <= 8'h00;
            res_valid_r   <= 1'b0;
            res_stable_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            next_pat_d_r <= bus.next_pat;

            if (stream_s) begin
                core_ui_in_r <= mem_r[rd_addr_s];
            end else begin
                core_ui_in_r <= 8'h00;
            end
            frame_start_r <= stream_s && (cnt_r == CNT_ZERO);

            if (state_r == ST_IDLE) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            if (expire_s) begin
                tmr_r <= {TMR_W{1'b0}};
            end else if (stream_s && (bus.mode == MODE_AUTO)) begin
                tmr_r <= tmr_r + TMR_W'(1);
            end else begin
                tmr_r <= tmr_r;
            end

            // Button edge and timer expiry merge into one pending request.
            if (adv_s) begin
                pend_r    <= 1'b0;
                pat_sel_r <= pat_sel_r + PAT_W'(1);
            end else begin
                pend_r    <= pend_r | rise_s | expire_s;
                pat_sel_r <= pat_sel_r;
            end

            if (adv_s || (state_nxt_s == ST_IDLE)) begin
                primed_r <= 1'b0;
            end else if (wrap_s && stream_s) begin
                primed_r <= 1'b1;
            end else begin
                primed_r <= primed_r;
            end

            stb_r        <= stb_nxt_s;
            res_stable_r <= (stb_nxt_s == STB_MAX);
            res_valid_r  <= capture_s;
            if (capture_s) begin
                res_index_r <= bus.core_index;
                res_value_r <= bus.core_value;
            end else begin
                res_index_r <= res_index_r;
                res_value_r <= res_value_r;
            end
        end
    end

    // Pattern RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.pat_we) begin
            mem_r[bus.pat_addr] <= bus.pat_wdata;
        end
    end

    assign bus.core_ui_in  = core_ui_in_r;
    assign bus.frame_start = frame_start_r;
    assign bus.pat_sel     = pat_sel_r;
    assign bus.res_index   = res_index_r;
    assign bus.res_value   = res_value_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_stable  = res_stable_r;
    assign bus.busy        = busy_r;
endmodule
